blockade_dl_ctrl: RTL

//  Upstream of the blockade core. Sits between hps_io's ioctl download stream and the core.

---
 rtl/blockade_pkg.sv | 22 ++
 rtl/blockade_dl_ctrl_if.sv | 25 ++
 rtl/blockade_rst_stretch.sv | 37 +++
 rtl/blockade_dl_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/blockade_pkg.sv
// Shared types and constants for the blockade download controller.
package blockade_pkg;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MODE = 8'd1;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  typedef enum logic [1:0] {
    GAME_BLOCKADE = 2'd0,
    GAME_COMOTION = 2'd1,
    GAME_HUSTLE   = 2'd2,
    GAME_BLASTO   = 2'd3
  } game_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } dl_state_t;

endpackage

// File: rtl/blockade_dl_ctrl_if.sv
// ioctl download stream from hps_io plus the ROM write port towards the core.
interface blockade_dl_ctrl_if #(
  parameter int ROM_AW = 14
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              dn_wr;
  logic [ROM_AW-1:0] dn_addr;
  logic [7:0]        dn_data;

  // Download source side: drives the byte stream, observes the ROM port.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_wr, dn_addr, dn_data
  );

  // Controller side: consumes the byte stream, drives the ROM port.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_wr, dn_addr, dn_data
  );
endinterface

// File: rtl/blockade_rst_stretch.sv
// Loadable down-counter that holds at zero; done_o marks the end of the hold.
module blockade_rst_stretch #(
  parameter int CNT_W = 5
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: a load wins, otherwise count down while enabled and not yet zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/blockade_dl_ctrl.sv
// Download controller in front of the blockade core: routes ROM bytes to the
// core, captures game mode and DIP bytes, and holds the core in reset until a
// ROM containing at least one nonzero byte has been loaded.
module blockade_dl_ctrl
  import blockade_pkg::*;
#(
  parameter int ROM_AW   = 14,
  parameter int RST_HOLD = 16
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                soft_reset,
  blockade_dl_ctrl_if.slave   io,
  output game_mode_t          game_mode,
  output logic [7:0]          sw0,
  output logic [7:0]          sw1,
  output logic [7:0]          sw2,
  output logic [7:0]          sw3,
  output logic [7:0]          sw4,
  output logic [7:0]          sw5,
  output logic [7:0]          sw6,
  output logic [7:0]          sw7,
  output logic                rom_valid,
  output logic                rom_overflow,
  output logic                core_reset,
  output logic                led_busy
);

  localparam int CNT_W = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);

  dl_state_t         state_q, state_d;
  logic              rom_dl_q;
  logic              rom_valid_q, rom_valid_d;
  logic              rom_ovf_q, rom_ovf_d;
  logic              core_reset_q, core_reset_d;
  logic              dn_wr_q, dn_wr_d;
  logic [ROM_AW-1:0] dn_addr_q, dn_addr_d;
  logic [7:0]        dn_data_q, dn_data_d;
  game_mode_t        mode_q, mode_d;
  logic [7:0]        sw_q [8];
  logic [7:0]        sw_d [8];

  logic rom_dl, rom_dl_rise, rom_dl_fall;
  logic addr_in_rng, rom_wr_ok, rom_wr_oor;
  logic cnt_load, hold_done;

  assign rom_dl      = io.ioctl_download && (io.ioctl_index == IDX_ROM);
  assign rom_dl_rise = rom_dl && !rom_dl_q;
  assign rom_dl_fall = !rom_dl && rom_dl_q;
  assign addr_in_rng = ((io.ioctl_addr >> ROM_AW) == '0);
  assign rom_wr_ok   = io.ioctl_wr && rom_dl && addr_in_rng;
  assign rom_wr_oor  = io.ioctl_wr && rom_dl && !addr_in_rng;

  // Post-load reset hold timer.
  blockade_rst_stretch #(
    .CNT_W (CNT_W)
  ) u_rst_stretch (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(RST_HOLD - 1)),
    .en_i       (state_q == HOLD),
    .done_o     (hold_done)
  );

  // Sequencer next state; a new ROM download restarts from LOAD in any state.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: ;
      LOAD: begin
        if (rom_dl_fall) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
        end
      end
      HOLD: begin
        if (hold_done) begin
          state_d = rom_valid_q ? RUN : IDLE;
        end
      end
      RUN: ;
      default: state_d = IDLE;
    endcase
    if (rom_dl_rise) begin
      state_d  = LOAD;
      cnt_load = 1'b0;
    end
  end

  // ROM port, load flags, mode/DIP capture and core reset next values.
  always_comb begin
    rom_valid_d = rom_valid_q;
    rom_ovf_d   = rom_ovf_q;
    dn_wr_d     = rom_wr_ok;
    dn_addr_d   = dn_addr_q;
    dn_data_d   = dn_data_q;
    mode_d      = mode_q;
    sw_d        = sw_q;
    // Entry clear comes first so a byte written on the rise cycle still counts.
    if (rom_dl_rise) begin
      rom_valid_d = 1'b0;
      rom_ovf_d   = 1'b0;
    end
    if (rom_wr_ok) begin
      dn_addr_d = io.ioctl_addr[ROM_AW-1:0];
      dn_data_d = io.ioctl_dout;
      if (io.ioctl_dout != 8'd0) begin
        rom_valid_d = 1'b1;
      end
    end
    if (rom_wr_oor) begin
      rom_ovf_d = 1'b1;
    end
    if (io.ioctl_wr && (io.ioctl_index == IDX_MODE) && (io.ioctl_addr == '0)) begin
      mode_d = game_mode_t'(io.ioctl_dout[1:0]);
    end
    if (io.ioctl_wr && (io.ioctl_index == IDX_DIP) && (io.ioctl_addr[24:3] == '0)) begin
      sw_d[io.ioctl_addr[2:0]] = io.ioctl_dout;
    end
    core_reset_d = reset || soft_reset || (state_d != RUN);
  end

  // State and output registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      rom_dl_q     <= 1'b0;
      rom_valid_q  <= 1'b0;
      rom_ovf_q    <= 1'b0;
      core_reset_q <= 1'b1;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      mode_q       <= GAME_BLOCKADE;
      for (int i = 0; i < 8; i++) begin
        sw_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rom_dl_q     <= rom_dl;
      rom_valid_q  <= rom_valid_d;
      rom_ovf_q    <= rom_ovf_d;
      core_reset_q <= core_reset_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      mode_q       <= mode_d;
      sw_q         <= sw_d;
    end
  end

  assign io.dn_wr     = dn_wr_q;
  assign io.dn_addr   = dn_addr_q;
  assign io.dn_data   = dn_data_q;
  assign game_mode    = mode_q;
  assign rom_valid    = rom_valid_q;
  assign rom_overflow = rom_ovf_q;
  assign core_reset   = core_reset_q;
  assign led_busy     = (state_q == LOAD);

  // DIP bank fan-out to the core's individual switch bytes.
  assign sw0 = sw_q[0];
  assign sw1 = sw_q[1];
  assign sw2 = sw_q[2];
  assign sw3 = sw_q[3];
  assign sw4 = sw_q[4];
  assign sw5 = sw_q[5];
  assign sw6 = sw_q[6];
  assign sw7 = sw_q[7];

endmodule
